// File: rtl/ne_fp_pkg.sv
// Shared constants and types for the FP -> FFP input converter.
// Holds the FFP word layout, mode bit indices, format biases and the operand class enum.
package ne_fp_pkg;

    localparam int FFP_W        = 47;
    localparam int FFP_NAN_BIT  = 46;
    localparam int FFP_INF_BIT  = 45;
    localparam int FFP_ZERO_BIT = 44;
    localparam int FFP_EXP_LSB  = 34;
    localparam int FFP_SIGN_BIT = 33;
    localparam int FFP_EXP_W    = 10;
    localparam int FFP_MANT_W   = 33;
    localparam int FFP_MAG_W    = 32;
    localparam int FFP_INT_W    = 22;

    localparam int MODE_INT8 = 0;
    localparam int MODE_FP8  = 1;
    localparam int MODE_TF32 = 2;
    localparam int MODE_FP32 = 3;

    localparam logic [9:0] FP32_BIAS    = 10'd127;
    localparam logic [9:0] E4M3_BIAS    = 10'd7;
    localparam logic [9:0] FP32_SUB_EXP = 10'h382;
    localparam logic [9:0] E4M3_SUB_EXP = 10'h3FA;

    typedef enum logic [2:0] {NORM, SUB, ZERO, INF, NAN} ffp_cls_e;

    typedef enum logic [2:0] {FMT_NONE, FMT_INT8, FMT_FP8, FMT_TF32, FMT_FP32} ffp_fmt_e;

    typedef struct packed {
        ffp_fmt_e                fmt;
        ffp_cls_e                cls;
        logic                    sign;
        logic [FFP_EXP_W-1:0]    exp;
        logic [FFP_MAG_W-1:0]    mag;
        logic [FFP_INT_W-1:0]    int_fld;
    } ffp_s1_t;

endpackage

// File: rtl/ne_fp_fp2ffp_m33_if.sv
// Valid/ready bundle between operand fetch, the FP -> FFP converter and the multiplier array.
interface ne_fp_fp2ffp_m33_if;
    logic                          in_vld;
    logic                          in_rdy;
    logic [31:0]                   din;
    logic [3:0]                    mode;
    logic                          out_vld;
    logic                          out_rdy;
    logic [ne_fp_pkg::FFP_W-1:0]   z;

    modport master (
        output in_vld, din, mode, out_rdy,
        input  in_rdy, out_vld, z
    );

    modport slave (
        input  in_vld, din, mode, out_rdy,
        output in_rdy, out_vld, z
    );
endinterface

// File: rtl/ne_fp_unpack_cls.sv
// Combinational classify/extract of one operand into the stage-1 record.
// Mode priority when several bits are set: int8 > fp8 > tf32 > fp32.
module ne_fp_unpack_cls
    import ne_fp_pkg::*;
(
    input  logic [31:0] din,
    input  logic [3:0]  mode,
    output ffp_s1_t     unp
);

    logic [31:0] fpw;

    always_comb begin
        unp      = '0;
        unp.fmt  = FMT_NONE;
        unp.cls  = ZERO;
        fpw      = din;
        if (mode[MODE_TF32]) begin
            fpw = {din[31:13], 13'b0};
        end

        if (mode[MODE_INT8]) begin
            unp.fmt     = FMT_INT8;
            unp.cls     = NORM;
            unp.int_fld = {{(FFP_INT_W-8){din[7]}}, din[7:0]};
        end else if (mode[MODE_FP8]) begin
            unp.fmt  = FMT_FP8;
            unp.sign = din[7];
            // E4M3 has no infinity; only the all-ones pattern is NaN
            if (din[6:0] == 7'h7F) begin
                unp.cls  = NAN;
                unp.sign = 1'b0;
            end else if (din[6:3] == 4'd0) begin
                if (din[2:0] == 3'd0) begin
                    unp.cls = ZERO;
                end else begin
                    unp.cls = SUB;
                    unp.exp = E4M3_SUB_EXP;
                    unp.mag = {1'b0, din[2:0], 28'b0};
                end
            end else begin
                unp.cls = NORM;
                unp.exp = {6'b0, din[6:3]} - E4M3_BIAS;
                unp.mag = {1'b1, din[2:0], 28'b0};
            end
        end else if (mode[MODE_TF32] || mode[MODE_FP32]) begin
            unp.fmt  = mode[MODE_TF32] ? FMT_TF32 : FMT_FP32;
            unp.sign = fpw[31];
            if (fpw[30:23] == 8'hFF) begin
                if (fpw[22:0] != 23'd0) begin
                    unp.cls  = NAN;
                    unp.sign = 1'b0;
                end else begin
                    unp.cls = INF;
                end
            end else if (fpw[30:23] == 8'd0) begin
                if (fpw[22:0] == 23'd0) begin
                    unp.cls = ZERO;
                end else begin
                    unp.cls = SUB;
                    unp.exp = FP32_SUB_EXP;
                    unp.mag = {1'b0, fpw[22:0], 8'b0};
                end
            end else begin
                unp.cls = NORM;
                unp.exp = {2'b0, fpw[30:23]} - FP32_BIAS;
                unp.mag = {1'b1, fpw[22:0], 8'b0};
            end
        end
    end

endmodule

// File: rtl/ne_fp_fp2ffp_m33.sv
// Two-stage valid/ready FP -> FFP converter with full backpressure.
// Optional NaN/Inf event counters are built when NE_FP2FFP_EXC_CNT_EN is defined.
module ne_fp_fp2ffp_m33
    import ne_fp_pkg::*;
#(
    parameter int INTWI = 22,
    parameter int EWI   = 10,
    parameter int SMWI  = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    ne_fp_fp2ffp_m33_if.slave    bus,
    output logic [31:0]          exc_cnt
);

    ffp_s1_t              unp;
    ffp_s1_t              s1_q, s1_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [FFP_W-1:0]     z_q, z_d;
    logic [FFP_W-1:0]     z_pack;
    logic [SMWI-1:0]      mant_mag;
    logic [SMWI-1:0]      mant_sgn;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 accept;

    ne_fp_unpack_cls u_unpack (
        .din  (bus.din),
        .mode (bus.mode),
        .unp  (unp)
    );

    assign s2_adv      = ~s2_vld_q | bus.out_rdy;
    assign s1_adv      = ~s1_vld_q | s2_adv;
    assign accept      = bus.in_vld & s1_adv;
    assign bus.in_rdy  = s1_adv;
    assign bus.out_vld = s2_vld_q;
    assign bus.z       = z_q;

    // Stage 2 datapath: apply the sign to the magnitude and pack the FFP word
    always_comb begin
        mant_mag = {1'b0, s1_q.mag};
        mant_sgn = s1_q.sign ? (~mant_mag + 1'b1) : mant_mag;
        z_pack   = '0;
        if (s1_q.fmt == FMT_INT8) begin
            z_pack[INTWI-1:0] = s1_q.int_fld;
        end else begin
            case (s1_q.cls)
                NAN: begin
                    z_pack[FFP_NAN_BIT] = 1'b1;
                end
                INF: begin
                    z_pack[FFP_INF_BIT] = 1'b1;
                    z_pack[SMWI]        = s1_q.sign;
                end
                ZERO: begin
                    z_pack[FFP_ZERO_BIT] = 1'b1;
                    z_pack[SMWI]         = s1_q.sign;
                end
                default: begin
                    z_pack[SMWI+1 +: EWI] = s1_q.exp;
                    z_pack[SMWI]          = s1_q.sign;
                    z_pack[SMWI-1:0]      = mant_sgn;
                end
            endcase
        end
    end

    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        z_d      = z_q;
        if (s1_adv) begin
            s1_vld_d = bus.in_vld;
            if (accept) begin
                s1_d = unp;
            end
        end
        // z only changes when stage 2 is free to take a new beat, so it holds during a stall
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                z_d = z_pack;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            z_q      <= '0;
        end else begin
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            z_q      <= z_d;
        end
    end

`ifdef NE_FP2FFP_EXC_CNT_EN
    logic [15:0] nan_cnt_q, nan_cnt_d;
    logic [15:0] inf_cnt_q, inf_cnt_d;

    // Saturating counters advance on the same edge that loads stage 1
    always_comb begin
        nan_cnt_d = nan_cnt_q;
        inf_cnt_d = inf_cnt_q;
        if (accept && (unp.cls == NAN) && (nan_cnt_q != 16'hFFFF)) begin
            nan_cnt_d = nan_cnt_q + 16'd1;
        end
        if (accept && (unp.cls == INF) && (inf_cnt_q != 16'hFFFF)) begin
            inf_cnt_d = inf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nan_cnt_q <= '0;
            inf_cnt_q <= '0;
        end else begin
            nan_cnt_q <= nan_cnt_d;
            inf_cnt_q <= inf_cnt_d;
        end
    end

    assign exc_cnt = {nan_cnt_q, inf_cnt_q};
`else
    assign exc_cnt = '0;
`endif

endmodule
